// File: rtl/soc_reset_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : soc_reset_sequencer_if                                          |
// | Brief    : Request/status bundle between the SoC side and the reset         |
// |            sequencer (soft reset, watchdog control, reset status).          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface soc_reset_sequencer_if;
  logic       soft_reset_req;
  logic       wdt_enable;
  logic       wdt_kick;
  logic       soc_reset;
  logic       soc_ready;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  // SoC / firmware side: raises requests, observes reset status
  modport master (
    output soft_reset_req, wdt_enable, wdt_kick,
    input  soc_reset, soc_ready, reset_cause, reset_count
  );

  // Sequencer side: consumes requests, drives reset status
  modport slave (
    input  soft_reset_req, wdt_enable, wdt_kick,
    output soc_reset, soc_ready, reset_cause, reset_count
  );
endinterface
`default_nettype wire

// File: rtl/soc_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : soc_reset_sequencer                                             |
// | Brief    : Synchronizes and stretches the board reset for the SoC, re-runs |
// |            the stretch on soft-reset requests and watchdog expiry, and     |
// |            records the cause and number of recovery resets.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module soc_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int WDT_CYCLES     = 400000000,
  parameter int WDT_WIDTH      = 32
) (
  input wire clk,
  input wire resetn,
  soc_reset_sequencer_if.slave bus
);

  // Stretch counter must hold STRETCH_CYCLES-1; keep at least one bit
  localparam int c_STRETCH_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [c_STRETCH_W-1:0] c_STRETCH_LAST = c_STRETCH_W'(STRETCH_CYCLES - 1);
  localparam logic [WDT_WIDTH-1:0]   c_WDT_LAST     = WDT_WIDTH'(WDT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_STRETCH = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_STRETCH_W-1:0] r_stretch;
  logic [WDT_WIDTH-1:0]   r_wdt;
  logic                   r_soc_reset;
  logic                   r_soc_ready;
  logic [1:0]             r_reset_cause;
  logic [7:0]             r_reset_count;

  logic w_release;
  logic w_wdt_expire;
  logic w_trigger;

  // Release is only seen once a 1 has walked through the whole chain
  assign w_release = r_sync[SYNC_STAGES-1];

  // A kick in the expiry cycle takes precedence and suppresses the reset
  assign w_wdt_expire = bus.wdt_enable && !bus.wdt_kick && (r_wdt == c_WDT_LAST);
  assign w_trigger    = bus.soft_reset_req || w_wdt_expire;

  // Reset-release synchronizer: asserts asynchronously, releases through the chain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Sequencer FSM with watchdog, cause/count bookkeeping and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_HOLD;
      r_stretch     <= '0;
      r_wdt         <= '0;
      r_soc_reset   <= 1'b1;
      r_soc_ready   <= 1'b0;
      r_reset_cause <= 2'd0;
      r_reset_count <= 8'd0;
    end else begin
      case (r_state)
        S_HOLD: begin
          r_wdt <= '0;
          if (w_release) begin
            r_state   <= S_STRETCH;
            r_stretch <= '0;
          end
        end

        S_STRETCH: begin
          r_wdt <= '0;
          if (r_stretch == c_STRETCH_LAST) begin
            r_state     <= S_RUN;
            r_soc_reset <= 1'b0;
            r_soc_ready <= 1'b1;
          end else begin
            r_stretch <= r_stretch + c_STRETCH_W'(1);
          end
        end

        S_RUN: begin
          if (w_trigger) begin
            // Watchdog wins the cause when both events land together
            r_state       <= S_STRETCH;
            r_stretch     <= '0;
            r_wdt         <= '0;
            r_soc_reset   <= 1'b1;
            r_soc_ready   <= 1'b0;
            r_reset_cause <= w_wdt_expire ? 2'd2 : 2'd1;
            if (r_reset_count != 8'hFF) begin
              r_reset_count <= r_reset_count + 8'd1;
            end
          end else if (bus.wdt_kick) begin
            r_wdt <= '0;
          end else if (bus.wdt_enable) begin
            r_wdt <= r_wdt + WDT_WIDTH'(1);
          end
        end

        default: begin
          r_state     <= S_HOLD;
          r_soc_reset <= 1'b1;
          r_soc_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.soc_reset   = r_soc_reset;
  assign bus.soc_ready   = r_soc_ready;
  assign bus.reset_cause = r_reset_cause;
  assign bus.reset_count = r_reset_count;

endmodule
`default_nettype wire

// File: tb/tb_soc_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_soc_reset_sequencer                                          |
// | Brief    : Directed self-checking bench for soc_reset_sequencer with       |
// |            SYNC_STAGES=2, STRETCH_CYCLES=4, WDT_CYCLES=20.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_soc_reset_sequencer;

  localparam int SYNC_STAGES    = 2;
  localparam int STRETCH_CYCLES = 4;
  localparam int WDT_CYCLES     = 20;
  localparam int WDT_WIDTH      = 8;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  soc_reset_sequencer_if bus ();

  soc_reset_sequencer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .STRETCH_CYCLES (STRETCH_CYCLES),
    .WDT_CYCLES     (WDT_CYCLES),
    .WDT_WIDTH      (WDT_WIDTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge, where outputs are sampled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Release resetn and follow the sync + stretch sequence to RUN (7th edge)
  task automatic release_and_check(input string tag);
    resetn = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + STRETCH_CYCLES; k++) begin
      tick();
      check({tag, "_hold"}, 32'(bus.soc_reset), 32'd1);
    end
    tick();
    check({tag, "_rst_fall"}, 32'(bus.soc_reset), 32'd0);
    check({tag, "_ready"},    32'(bus.soc_ready), 32'd1);
    check({tag, "_cause"},    32'(bus.reset_cause), 32'd0);
    check({tag, "_count"},    32'(bus.reset_count), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn             = 1'b0;
    bus.soft_reset_req = 1'b0;
    bus.wdt_enable     = 1'b0;
    bus.wdt_kick       = 1'b0;

    // Power-on: hold reset for 5 clocks
    repeat (5) tick();
    check("por_rst",   32'(bus.soc_reset),   32'd1);
    check("por_ready", 32'(bus.soc_ready),   32'd0);
    check("por_cause", 32'(bus.reset_cause), 32'd0);
    check("por_count", 32'(bus.reset_count), 32'd0);
    release_and_check("por");

    // Soft reset: one-clock pulse, reset high for exactly 4 clocks
    bus.soft_reset_req = 1'b1;
    tick();
    bus.soft_reset_req = 1'b0;
    check("soft_rst",   32'(bus.soc_reset),   32'd1);
    check("soft_ready", 32'(bus.soc_ready),   32'd0);
    check("soft_cause", 32'(bus.reset_cause), 32'd1);
    check("soft_count", 32'(bus.reset_count), 32'd1);
    repeat (3) tick();
    check("soft_still", 32'(bus.soc_reset), 32'd1);
    tick();
    check("soft_done",  32'(bus.soc_reset), 32'd0);
    check("soft_run",   32'(bus.soc_ready), 32'd1);

    // Watchdog expiry on the 20th enabled RUN clock
    bus.wdt_enable = 1'b1;
    repeat (19) tick();
    check("wdt_pre", 32'(bus.soc_ready), 32'd1);
    tick();
    check("wdt_rst",   32'(bus.soc_reset),   32'd1);
    check("wdt_cause", 32'(bus.reset_cause), 32'd2);
    check("wdt_count", 32'(bus.reset_count), 32'd2);
    repeat (4) tick();
    check("wdt_run", 32'(bus.soc_ready), 32'd1);

    // Kicking every 10 clocks for 200 clocks keeps the SoC running
    for (int i = 0; i < 200; i++) begin
      bus.wdt_kick = (i % 10 == 9);
      tick();
    end
    bus.wdt_kick = 1'b0;
    check("kick_ready", 32'(bus.soc_ready),   32'd1);
    check("kick_count", 32'(bus.reset_count), 32'd2);

    // Disabled watchdog holds its count
    bus.wdt_enable = 1'b0;
    repeat (100) tick();
    check("dis_ready", 32'(bus.soc_ready),   32'd1);
    check("dis_count", 32'(bus.reset_count), 32'd2);

    // Kick on the exact expiry cycle wins
    bus.wdt_enable = 1'b1;
    repeat (19) tick();
    bus.wdt_kick = 1'b1;
    tick();
    bus.wdt_kick = 1'b0;
    check("kexp_rst",   32'(bus.soc_reset),   32'd0);
    check("kexp_ready", 32'(bus.soc_ready),   32'd1);
    check("kexp_count", 32'(bus.reset_count), 32'd2);

    // Soft request coinciding with expiry: one reset, cause watchdog
    repeat (19) tick();
    bus.soft_reset_req = 1'b1;
    tick();
    bus.soft_reset_req = 1'b0;
    bus.wdt_enable     = 1'b0;
    check("both_rst",   32'(bus.soc_reset),   32'd1);
    check("both_cause", 32'(bus.reset_cause), 32'd2);
    check("both_count", 32'(bus.reset_count), 32'd3);
    repeat (4) tick();
    check("both_run",    32'(bus.soc_ready),   32'd1);
    check("both_single", 32'(bus.reset_count), 32'd3);

    // Held soft request re-triggers every 5 clocks
    bus.soft_reset_req = 1'b1;
    tick();
    check("held1_rst",   32'(bus.soc_reset),   32'd1);
    check("held1_cause", 32'(bus.reset_cause), 32'd1);
    check("held1_count", 32'(bus.reset_count), 32'd4);
    repeat (3) tick();
    check("held_stretch", 32'(bus.soc_reset), 32'd1);
    tick();
    check("held_run", 32'(bus.soc_ready), 32'd1);
    tick();
    check("held2_rst",   32'(bus.soc_reset),   32'd1);
    check("held2_count", 32'(bus.reset_count), 32'd5);
    bus.soft_reset_req = 1'b0;

    // Async reset mid-STRETCH, between clock edges
    repeat (2) tick();
    #2 resetn = 1'b0;
    #1;
    check("async_rst",   32'(bus.soc_reset),   32'd1);
    check("async_ready", 32'(bus.soc_ready),   32'd0);
    check("async_cause", 32'(bus.reset_cause), 32'd0);
    check("async_count", 32'(bus.reset_count), 32'd0);
    repeat (2) tick();
    release_and_check("repor");

    // Saturation: 260 held-soft resets, then one more
    bus.soft_reset_req = 1'b1;
    repeat (1 + 259 * 5) tick();
    check("sat_rst",   32'(bus.soc_reset),   32'd1);
    check("sat_count", 32'(bus.reset_count), 32'd255);
    repeat (5) tick();
    check("sat_more_rst",   32'(bus.soc_reset),   32'd1);
    check("sat_more_count", 32'(bus.reset_count), 32'd255);
    bus.soft_reset_req = 1'b0;
    repeat (4) tick();
    check("sat_run",   32'(bus.soc_ready),   32'd1);
    check("sat_cause", 32'(bus.reset_cause), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
